// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Latches operands on start, runs 32 shift-add or restoring-divide steps,
// then applies sign correction and special-case overrides in one finish cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [2:0]       funct3_i,
   input  logic [WIDTH-1:0] rs1_i,
   input  logic [WIDTH-1:0] rs2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t             state_q;
   logic [2:0]         op_q;
   logic               neg_q;      // product / quotient is negative
   logic               sa_q;       // dividend sign, used for the remainder
   logic [4:0]         cnt_q;
   logic [WIDTH-1:0]   den_q;      // multiplicand (mul) or divisor (div)
   logic [2*WIDTH-1:0] acc_q;      // {hi, lo}: lo holds multiplier / dividend-quotient
   logic [WIDTH-1:0]   rem_q;
   logic               spec_q;
   logic [WIDTH-1:0]   spec_val_q;
   logic               busy_q, done_q;
   logic [WIDTH-1:0]   result_q;

   // operand decode at latch time
   logic             is_div, a_signed, b_signed, sa, sb, div0, ovf;
   logic [WIDTH-1:0] mag_a, mag_b, spec_val;

   // Decode signedness, magnitudes and division special cases from the raw inputs.
   always_comb begin
      is_div   = funct3_i[2];
      a_signed = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
      b_signed = is_div ? ~funct3_i[0] : ~funct3_i[1];
      sa       = a_signed & rs1_i[WIDTH-1];
      sb       = b_signed & rs2_i[WIDTH-1];
      mag_a    = sa ? -rs1_i : rs1_i;
      mag_b    = sb ? -rs2_i : rs2_i;
      div0     = is_div && (rs2_i == '0);
      ovf      = is_div && !funct3_i[0] && (rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_i == '1);
      // overflow DIV returns the dividend itself (most negative value)
      spec_val = div0 ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);
   end

   // one iteration step for either datapath
   logic [WIDTH:0]     mul_sum, div_shl, div_diff;
   logic               qbit;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   rem_d;

   // Next accumulator / remainder for the current iteration.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, den_q} : '0);
      div_shl  = {rem_q, acc_q[WIDTH-1]};
      div_diff = div_shl - {1'b0, den_q};
      qbit     = (div_shl >= {1'b0, den_q});
      if (op_q[2]) begin
         acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
         rem_d = qbit ? div_diff[WIDTH-1:0] : div_shl[WIDTH-1:0];
      end else begin
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         rem_d = rem_q;
      end
   end

   // sign-corrected result selection
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rmd, result_d;

   // Apply sign rules and pick the architectural result for op_q.
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rmd  = sa_q ? -rem_q : rem_q;
      case (op_q)
         3'b000:                 result_d = prod[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: result_d = prod[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         result_d = quo;
         default:                result_d = rmd;
      endcase
      if (spec_q) result_d = spec_val_q;
   end

   // Control FSM with registered busy/done/result; reset wins over everything.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         op_q       <= '0;
         neg_q      <= 1'b0;
         sa_q       <= 1'b0;
         cnt_q      <= '0;
         den_q      <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               op_q       <= funct3_i;
               neg_q      <= sa ^ sb;
               sa_q       <= sa;
               cnt_q      <= '0;
               den_q      <= is_div ? mag_b : mag_a;
               acc_q      <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
               rem_q      <= '0;
               spec_q     <= div0 | ovf;
               spec_val_q <= spec_val;
               busy_q     <= 1'b1;
               state_q    <= CALC;
            end
            CALC: begin
               acc_q <= acc_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= FINISH;
            end
            FINISH: begin
               result_q <= result_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected result and
// completion cycle; the monitor pops and checks on every done pulse.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        busy, done;
   logic [31:0] result;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .funct3_i(funct3),
      .rs1_i(rs1), .rs2_i(rs2), .busy_o(busy), .done_o(done), .result_o(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      int          id;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   logic rst_at_edge = 1'b0;
   logic fin_req = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   run = 0;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= reset;
   end

   task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s op%0d got=%h exp=%h", nm, id, got, exp);
      end
   endtask

   // monitor: all comparisons happen here
   always @(negedge clk) begin
      exp_t e;
      if (rst_at_edge) begin
         chk("rst_busy", -1, {31'b0, busy}, 32'd0);
         chk("rst_done", -1, {31'b0, done}, 32'd0);
         chk("rst_result", -1, result, 32'd0);
      end
      if (done) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done cyc=%0d result=%h exp=none", cyc, result);
         end else begin
            e = q.pop_front();
            chk("result", e.id, result, e.res);
            chk("done_cycle", e.id, cyc, e.cyc);
            chk("busy_len", e.id, run, 33);
         end
         run = 0;
      end else if (busy) run++;
      else run = 0;
      if (fin_req) begin
         chk("pending_left", -1, q.size(), 0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
      if (cyc > 4000) begin
         total++; bad++;
         $display("FAIL timeout cyc=%0d exp<=4000", cyc);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   // drive one start pulse; optionally register the expected completion
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push, input int id);
      exp_t e;
      @(negedge clk);
      start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
      if (push) begin
         e.res = exp; e.cyc = cyc + 1 + 33; e.id = id;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) break;
      end
   endtask

   localparam int NV = 14;
   logic [2:0]  v_f   [NV] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101,
                               3'b111, 3'b101, 3'b111, 3'b100, 3'b100, 3'b110, 3'b110};
   logic [31:0] v_a   [NV] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'd5,
                               32'h80000000, 32'h80000000, 32'd5};
   logic [31:0] v_b   [NV] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
   logic [31:0] v_exp [NV] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF,
                               32'h80000000, 32'd0, 32'd5};

   initial begin
      exp_t e;
      reset = 1'b1; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         issue(v_f[i], v_a[i], v_b[i], v_exp[i], 1'b1, i);
         wait_done();
      end

      // start while busy is ignored; start in the done cycle is accepted
      issue(3'b000, 32'd3, 32'd4, 32'd12, 1'b1, 20);
      repeat (9) @(negedge clk);
      start = 1'b1; funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      start = 1'b1; funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd3;
      e.res = 32'd3; e.cyc = cyc + 1 + 33; e.id = 21;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // reset mid-operation discards the op (nothing pushed)
      issue(3'b100, 32'd1000, 32'd7, 32'd0, 1'b0, 22);
      repeat (13) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      // normal op after reset
      issue(3'b000, 32'd7, 32'd6, 32'd42, 1'b1, 23);
      wait_done();
      repeat (3) @(negedge clk);
      fin_req = 1'b1;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Operands are latched on a start pulse. A 32-bit result is produced after a fixed latency, and busy stalls the pipeline meanwhile.
- `result` feeds the 32-bit 2:1 writeback select mux; `done` is the mux control that picks the M-extension result over the ALU result.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  32  operand A (multiplicand / dividend).
- rs2  input  32  operand B (multiplier / divisor).
- busy  output  1  high while an op is in flight.
- done  output  1  one-cycle pulse; result is valid.
- result  output  32  registered result; holds until the next done.

Behaviour:
- Reset (synchronous, priority over everything, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0.
  - Iteration counter and internal registers cleared.
  - An in-flight op is discarded and produces no done.
- States: IDLE, CALC, FINISH.
- IDLE, start=1 at edge N:
  - Latch funct3, rs1, rs2 and the operand signs.
  - Load magnitudes: signed operands are two's-complement negated if negative. MULHSU treats only rs1 as signed; MULHU, DIVU and REMU are unsigned.
  - counter=0, busy=1, state->CALC.
- IDLE, start=0: no change; done=0.
- CALC: one iteration per edge, at edges N+1..N+32.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division, one quotient bit per iteration, 33-bit partial remainder.
  - At the edge where counter==31: state->FINISH.
- FINISH, edge N+33:
  - Apply sign correction, then register the result.
  - done=1, busy=0, state->IDLE.
  - done deasserts at the next edge unless another op completes there.
- Result selection:
  - MUL = product[31:0].
  - MULH/MULHSU/MULHU = product[63:32].
  - DIV/DIVU = quotient; REM/REMU = remainder.
- Sign rules:
  - Product negative iff the signed operand signs differ.
  - Quotient negative iff signs differ.
  - Remainder takes the sign of the dividend.
- Fixed latency: done is high 33 cycles after the start-sampling edge, for every op including the special cases below.
- Division special cases (decided at latch time; override the datapath result in FINISH):
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1 unmodified.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Handshake:
  - start while busy=1 is ignored; operands are not re-latched.
  - start in the cycle done=1 is accepted, since state is IDLE. busy rises at that edge, giving back-to-back ops with no bubble.
- Input changes after the start edge have no effect on the op in flight.
- result changes only on the FINISH edge or on reset.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB.
  - busy high for exactly 33 cycles.
  - done a single-cycle pulse at cycle 33.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Divisor zero and overflow:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 5/0 -> 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - All at 33-cycle latency.
- Start while busy:
  - Start MUL 3x4; pulse start with DIVU 9/3 at cycle 10 -> ignored; result 12 at cycle 33, no second done.
  - Then assert start DIVU 9/3 in the done cycle -> accepted; result 3 after a further 33 cycles.
- Reset mid-operation:
  - Assert reset at cycle 15 of a DIV -> next cycle busy=0, done=0, result=0; no done appears later.
  - A new start after reset completes normally.
